// File: rtl/shift_register_serializer.sv
// -----------------------------------------------------------------------------
// shift_register_serializer
//
// Parallel-in, serial-out transmitter. A WIDTH-bit word is captured through a
// load/ready handshake and shifted out one bit per accepted cycle over a
// valid/ready serial handshake. The consumer may stall at any bit.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   LSB_FIRST  0: MSB transmitted first, 1: LSB transmitted first
//   CNT_W      width of bitCount
//
// Ports
//   CLK          in   rising-edge clock
//   resetN       in   asynchronous active-low reset
//   dataIn       in   word to transmit, sampled on an accepted load
//   load         in   load request, accepted when load && ready
//   ready        out  block can accept a word
//   serialOut    out  current serial bit
//   serialValid  out  serialOut holds a valid bit
//   serialReady  in   consumer accepts the bit when serialValid && serialReady
//   frameLast    out  presented bit is the final bit of the word
//   done         out  one-cycle pulse after the final bit is accepted
//   bitCount     out  bits still to be accepted, including the presented one
//
// Every output is a register or a decode of registered state; there is no
// combinational path from load or serialReady to any output.
// -----------------------------------------------------------------------------
module shift_register_serializer #(
    parameter int WIDTH     = 32,
    parameter int LSB_FIRST = 0,
    parameter int CNT_W     = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             resetN,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             load,
    output logic             ready,
    output logic             serialOut,
    output logic             serialValid,
    input  logic             serialReady,
    output logic             frameLast,
    output logic             done,
    output logic [CNT_W-1:0] bitCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q,  sreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               ready_q, ready_d;
    logic               out_bit_s;

    // Next-state, shift-register and bit-counter update.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load && ready_q) begin
                    sreg_d  = dataIn;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (serialReady) begin
                    // Shift toward the output end; the vacated bit fills with zero.
                    if (LSB_FIRST != 0) begin
                        sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
                    end else begin
                        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
                sreg_d  = {WIDTH{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
            default: begin
                state_d = IDLE;
                sreg_d  = {WIDTH{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // ready is registered so it stays low during reset and rises on the first
    // edge after release, while still tracking the IDLE state thereafter.
    always_comb begin
        ready_d = (state_d == IDLE);
    end

    // State, shift register, counter and ready registers.
    always_ff @(posedge CLK or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            sreg_q  <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Output end of the shift register depends on transmit order.
    always_comb begin
        if (LSB_FIRST != 0) begin
            out_bit_s = sreg_q[0];
        end else begin
            out_bit_s = sreg_q[WIDTH-1];
        end
    end

    // Output decode from registered state only.
    always_comb begin
        ready       = ready_q;
        serialValid = (state_q == SHIFT);
        serialOut   = (state_q == SHIFT) ? out_bit_s : 1'b0;
        frameLast   = (state_q == SHIFT) && (cnt_q == CNT_W'(1));
        done        = (state_q == DONE);
        bitCount    = cnt_q;
    end

endmodule

// File: doc/shift_register_serializer.md
# shift_register_serializer

Parallel-in, serial-out transmitter for 32-bit datapath words; the transmit-side counterpart of the enabled parallel-load register in the datapath. It captures a word through a load/ready handshake and shifts it out one bit per accepted cycle over a valid/ready serial handshake. It signals the last bit and completion, and tolerates consumer back-pressure at any bit.

## Interface

- WIDTH, 32, word width in bits (≥2)
- LSB_FIRST, 0, 0 = MSB transmitted first, 1 = LSB first
- CNT_W, $clog2(WIDTH)+1, width of bitCount
- CLK  in  1  clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- dataIn  in  WIDTH  word to transmit, sampled on accepted load
- load  in  1  load request; accepted on a rising edge where load && ready
- ready  out  1  block can accept a word
- serialOut  out  1  current serial bit
- serialValid  out  1  serialOut holds a valid bit
- serialReady  in  1  consumer accepts the bit on a rising edge where serialValid && serialReady
- frameLast  out  1  current presented bit is the final bit of the word
- done  out  1  one-cycle pulse after the final bit is accepted
- bitCount  out  CNT_W  bits still to be accepted, including the presented bit

## Operation

- Reset values: ready=0 while resetN low, then 1 from the first cycle after release (state IDLE); serialOut=0, serialValid=0, frameLast=0, done=0, bitCount=0; shift register cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: ready=1, serialValid=0, serialOut=0.
  - On load && ready: shift register <= dataIn, bitCount <= WIDTH, go to SHIFT.
- SHIFT: ready=0, serialValid=1.
  - serialOut = sreg[WIDTH-1] when LSB_FIRST=0, sreg[0] when LSB_FIRST=1.
  - frameLast = (bitCount==1).
  - On serialValid && serialReady: shift toward the output end, zero-fill the vacated bit, bitCount <= bitCount-1.
  - If bitCount was 1 on acceptance, go to DONE.
  - With serialReady low: hold sreg, serialOut, bitCount and frameLast unchanged; no timeout.
- DONE: done=1, ready=0, serialValid=0, bitCount=0; unconditionally go to IDLE next cycle.
- load while ready=0 (SHIFT or DONE) is ignored and not queued. dataIn changes outside the accept edge have no effect.
- Reset assertion mid-frame aborts the frame immediately and asynchronously: all outputs return to reset values and the partial word is discarded. No done pulse is generated.
- serialReady high while serialValid=0 has no effect.

## Timing

- The load accept edge is E. The first bit is presented in the cycle after E: no combinational load-to-serialValid path.
- With serialReady held high, bit i (0-based) is presented in cycle E+1+i. The last bit is presented in cycle E+WIDTH with frameLast=1. done=1 in cycle E+WIDTH+1. ready=1 in cycle E+WIDTH+2.
- Minimum spacing between accepted loads is WIDTH+2 cycles. Each stalled cycle adds one.
- All outputs are registered or decoded from registered state only. No combinational path from serialReady or load to any output.

## Test plan

- Reset, then load 32'h00000001 with serialReady=1, MSB-first -> 31 zeros then a 1. frameLast high only on bit 32. done pulses once at E+33. ready returns at E+34. bitCount counts 32→1.
- Load 32'hFFFFFFFF, toggle serialReady 1/0 each cycle -> 32 ones. Each bit is held stable across stall cycles. Acceptance takes 64 cycles and done follows the 32nd accept.
- LSB_FIRST=1, load 32'hFF0000FF -> 8 ones, 16 zeros, 8 ones. Load 32'h00000001 -> a 1 followed by 31 zeros.
- Pulse load with 32'h12345678 during the SHIFT of 32'hFF0000FF -> second load is ignored. The output stream is exactly the first word. After done, ready=1 and no stray frame follows.
- Drop resetN at bit 10 of a frame -> in the same cycle serialValid=0, bitCount=0 and done=0. After release, ready=1 and a new load of 32'h00000000 transmits 32 zeros cleanly.
- Hold load high with dataIn=32'hA5A5A5A5 and serialReady=1 -> back-to-back frames are accepted every 34 cycles, each with exactly one done pulse.
